// File: rtl/mux10_rr_arbiter.sv
// Round-robin owner of a 10:1 mux: grant 1 cycle after an eligible request, bounded dwell, 1-cycle GAP then IDLE.
// No backpressure; the owner leaves early via rel, dropping req, or being masked.
module mux10_rr_arbiter #(
  parameter int unsigned DWELL_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req,
  input  logic [9:0] mask,
  input  logic       rel,
  input  logic       y_in,
  output logic [3:0] sel,
  output logic       en,
  output logic [9:0] gnt,
  output logic       busy,
  output logic       y_smp,
  output logic       smp_vld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL_MAX - 1);

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] dwell_q, dwell_d;
  logic [9:0] gnt_q, gnt_d;
  logic       y_smp_q, y_smp_d;
  logic       smp_vld_q, smp_vld_d;

  logic [9:0] elig;
  logic       win_vld;
  logic [3:0] win_idx;
  logic [4:0] cand;
  logic       exit_grant;

  assign elig = req & ~mask;

  // Cyclic search starting at ptr; the first hit wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < 10; k++) begin
      cand = 5'(ptr_q) + 5'(k);
      if (cand >= 5'd10) cand = cand - 5'd10;
      if (!win_vld && elig[cand[3:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[3:0];
      end
    end
  end

  assign exit_grant = rel | ~req[sel_q] | mask[sel_q] | (dwell_q == DWELL_LAST);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    dwell_d   = dwell_q;
    gnt_d     = gnt_q;
    smp_vld_d = 1'b0;
    y_smp_d   = y_smp_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          state_d = GRANT;
          sel_d   = win_idx;
          gnt_d   = 10'b1 << win_idx;
          dwell_d = '0;
        end
      end
      GRANT: begin
        smp_vld_d = 1'b1;
        y_smp_d   = y_in;
        if (exit_grant) begin
          state_d = GAP;
          gnt_d   = '0;
          dwell_d = '0;
          ptr_d   = (sel_q == 4'd9) ? 4'd0 : sel_q + 4'd1;
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      dwell_q   <= '0;
      gnt_q     <= '0;
      y_smp_q   <= 1'b0;
      smp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      dwell_q   <= dwell_d;
      gnt_q     <= gnt_d;
      y_smp_q   <= y_smp_d;
      smp_vld_q <= smp_vld_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign en      = |gnt_q;
  assign busy    = (state_q != IDLE);
  assign y_smp   = y_smp_q;
  assign smp_vld = smp_vld_q;

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// Vector table bench for mux10_rr_arbiter: expected outputs queued at drive time, popped after each edge.
module tb_mux10_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] req = '0;
  logic [9:0] mask = '0;
  logic       rel = 1'b0;
  logic       y_in = 1'b0;
  logic [3:0] sel;
  logic       en;
  logic [9:0] gnt;
  logic       busy;
  logic       y_smp;
  logic       smp_vld;

  int checks = 0;
  int failures = 0;

  mux10_rr_arbiter #(.DWELL_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .rel(rel), .y_in(y_in),
    .sel(sel), .en(en), .gnt(gnt), .busy(busy), .y_smp(y_smp), .smp_vld(smp_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         pre_rst;
    logic [9:0] req;
    logic [9:0] mask;
    logic       rel;
    logic       y;
    logic [17:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [17:0] exp_q[$];

  function automatic logic [17:0] pack(input logic [3:0] s, input logic e, input logic [9:0] g,
                                       input logic b, input logic ys, input logic v);
    return {s, e, g, b, ys, v};
  endfunction

  function automatic logic [9:0] onehot(input int c);
    logic [9:0] one;
    one = 10'd1;
    return one << c;
  endfunction

  function automatic void add(input bit r, input logic [9:0] rq, input logic [9:0] mk,
                              input logic rl, input logic yy, input logic [3:0] s, input logic e,
                              input logic [9:0] g, input logic b, input logic ys, input logic v);
    vec_t t;
    t.pre_rst = r;
    t.req     = rq;
    t.mask    = mk;
    t.rel     = rl;
    t.y       = yy;
    t.exp     = pack(s, e, g, b, ys, v);
    tbl.push_back(t);
  endfunction

  function automatic logic [17:0] got_now();
    return {sel, en, gnt, busy, y_smp, smp_vld};
  endfunction

  task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got{sel,en,gnt,busy,y_smp,vld}=%h required=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    mask = '0;
    rel  = 1'b0;
    y_in = 1'b0;
    #1;
    chk("reset_state", got_now(), '0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Dwell limit on a lone requester, then re-grant, release, idle hold.
    add(1, 10'h001, 0, 0, 0, 0, 1, 10'h001, 1, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 10'h001, 0, 0, 0, 0, 1, 10'h001, 1, 0, 1);
    add(0, 10'h001, 0, 0, 0, 0, 0, 10'h000, 1, 0, 1);
    add(0, 10'h001, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    add(0, 10'h001, 0, 0, 0, 0, 1, 10'h001, 1, 0, 0);
    add(0, 10'h001, 0, 1, 0, 0, 0, 10'h000, 1, 0, 1);
    add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);

    // Full rotation with rel on every third grant cycle.
    for (int c = 0; c < 10; c++) begin
      add(c == 0, 10'h3FF, 0, 0, 0, 4'(c), 1, onehot(c), 1, 0, 0);
      add(0, 10'h3FF, 0, 0, 0, 4'(c), 1, onehot(c), 1, 0, 1);
      add(0, 10'h3FF, 0, 0, 0, 4'(c), 1, onehot(c), 1, 0, 1);
      add(0, 10'h3FF, 0, 1, 0, 4'(c), 0, 10'h000, 1, 0, 1);
      add(0, 10'h3FF, 0, 0, 0, 4'(c), 0, 10'h000, 0, 0, 0);
    end
    add(0, 10'h3FF, 0, 0, 0, 0, 1, 10'h001, 1, 0, 0);
    add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 1, 0, 1);

    // Pointer wrap 8 -> 9 -> 0 -> 9, and simultaneous exit causes.
    add(1, 10'h100, 0, 0, 0, 8, 1, 10'h100, 1, 0, 0);
    add(0, 10'h100, 0, 1, 0, 8, 0, 10'h000, 1, 0, 1);
    add(0, 10'h201, 0, 0, 0, 8, 0, 10'h000, 0, 0, 0);
    add(0, 10'h201, 0, 0, 0, 9, 1, 10'h200, 1, 0, 0);
    add(0, 10'h201, 0, 1, 0, 9, 0, 10'h000, 1, 0, 1);
    add(0, 10'h201, 0, 0, 0, 9, 0, 10'h000, 0, 0, 0);
    add(0, 10'h201, 0, 0, 0, 0, 1, 10'h001, 1, 0, 0);
    add(0, 10'h201, 0, 1, 0, 0, 0, 10'h000, 1, 0, 1);
    add(0, 10'h201, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    add(0, 10'h201, 0, 0, 0, 9, 1, 10'h200, 1, 0, 0);
    add(0, 10'h000, 0, 1, 0, 9, 0, 10'h000, 1, 0, 1);
    add(0, 10'h000, 0, 0, 0, 9, 0, 10'h000, 0, 0, 0);
    add(0, 10'h000, 0, 0, 0, 9, 0, 10'h000, 0, 0, 0);

    // y_in sampling during a 4-cycle grant; value held afterwards.
    add(0, 10'h001, 0, 0, 1, 0, 1, 10'h001, 1, 0, 0);
    add(0, 10'h001, 0, 0, 0, 0, 1, 10'h001, 1, 0, 1);
    add(0, 10'h001, 0, 0, 1, 0, 1, 10'h001, 1, 1, 1);
    add(0, 10'h001, 0, 0, 0, 0, 1, 10'h001, 1, 0, 1);
    add(0, 10'h001, 0, 1, 1, 0, 0, 10'h000, 1, 1, 1);
    add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 1, 0);
    add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 1, 0);

    // Owner 4: other channels churn, then mask[4] ends it and keeps it out.
    add(1, 10'h010, 10'h000, 0, 0, 4, 1, 10'h010, 1, 0, 0);
    add(0, 10'h3FF, 10'h3EF, 0, 0, 4, 1, 10'h010, 1, 0, 1);
    add(0, 10'h01F, 10'h00F, 0, 0, 4, 1, 10'h010, 1, 0, 1);
    add(0, 10'h010, 10'h010, 0, 0, 4, 0, 10'h000, 1, 0, 1);
    add(0, 10'h010, 10'h010, 0, 0, 4, 0, 10'h000, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 10'h010, 10'h010, 0, 0, 4, 0, 10'h000, 0, 0, 0);
    add(0, 10'h030, 10'h010, 0, 0, 5, 1, 10'h020, 1, 0, 0);
    add(0, 10'h010, 10'h010, 0, 0, 5, 0, 10'h000, 1, 0, 1);
    add(0, 10'h010, 10'h010, 0, 0, 5, 0, 10'h000, 0, 0, 0);
    add(0, 10'h010, 10'h010, 0, 0, 5, 0, 10'h000, 0, 0, 0);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      logic [17:0] e;
      if (tbl[i].pre_rst) do_reset();
      req  = tbl[i].req;
      mask = tbl[i].mask;
      rel  = tbl[i].rel;
      y_in = tbl[i].y;
      exp_q.push_back(tbl[i].exp);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d", i), got_now(), e);
    end

    // Asynchronous reset while channel 6 owns the mux.
    do_reset();
    req = 10'h040;
    tick();
    chk("async_pre", got_now(), pack(6, 1, 10'h040, 1, 0, 0));
    #3;
    rst = 1'b1;
    #1;
    chk("async_mid", got_now(), '0);
    #1;
    rst = 1'b0;
    req = 10'h3FF;
    tick();
    chk("async_post", got_now(), pack(0, 1, 10'h001, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
